// File: rtl/store_rmw_if.sv
// Bundle of request and memory-side signals for store_rmw_controller.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_ready is high only while idle.
interface store_rmw_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              misaligned;
    logic              err;
    logic [2:0]        fsm_state;

    modport slave (
        input  req_valid, funct3, addr, wdata, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               done, misaligned, err, fsm_state
    );

    modport master (
        output req_valid, funct3, addr, wdata, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               done, misaligned, err, fsm_state
    );
endinterface

// File: rtl/store_rmw_controller.sv
// Byte/half/word store engine: sub-word stores do read-merge-write on a 32-bit word memory.
// All outputs are registered and follow the FSM state; fsm_state exposes the state for debug.
module store_rmw_controller #(
    parameter int ADDR_W = 6
) (
    input logic       clk,
    input logic       rst,
    store_rmw_if.slave bus
);
    localparam logic [2:0] F3_SB = 3'h0;
    localparam logic [2:0] F3_SH = 3'h1;
    localparam logic [2:0] F3_SW = 3'h2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        mis_q;
    logic [31:0] merged;

    assign bus.fsm_state = state;

    // Lane replacement into the word read back from memory.
    always_comb begin
        merged = bus.mem_rdata;
        if (f3_q == F3_SB) begin
            case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            f3_q           <= 3'd0;
            lane_q         <= 2'd0;
            wdata_q        <= 32'd0;
            err_q          <= 1'b0;
            mis_q          <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.mem_addr   <= '0;
            bus.mem_rd_en  <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.mem_wdata  <= 32'd0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.misaligned <= 1'b0;
        end else begin
            bus.mem_rd_en  <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        f3_q          <= bus.funct3;
                        lane_q        <= bus.addr[1:0];
                        wdata_q       <= bus.wdata;
                        bus.mem_addr  <= {bus.addr[ADDR_W-1:2], 2'b00};
                        bus.req_ready <= 1'b0;
                        err_q         <= 1'b0;
                        mis_q         <= 1'b0;
                        case (bus.funct3)
                            F3_SB: begin
                                state         <= READ;
                                bus.mem_rd_en <= 1'b1;
                            end
                            F3_SH: begin
                                state         <= READ;
                                bus.mem_rd_en <= 1'b1;
                                mis_q         <= bus.addr[0];
                            end
                            F3_SW: begin
                                state         <= WRITE;
                                bus.mem_wr_en <= 1'b1;
                                bus.mem_wdata <= bus.wdata;
                                mis_q         <= (bus.addr[1:0] != 2'b00);
                            end
                            default: begin
                                // Illegal type goes straight to the response, no memory traffic.
                                state    <= RESP;
                                err_q    <= 1'b1;
                                bus.done <= 1'b1;
                                bus.err  <= 1'b1;
                            end
                        endcase
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state         <= WRITE;
                    bus.mem_wr_en <= 1'b1;
                    bus.mem_wdata <= merged;
                end
                WRITE: begin
                    state          <= RESP;
                    bus.done       <= 1'b1;
                    bus.err        <= err_q;
                    bus.misaligned <= mis_q;
                end
                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_store_rmw_controller.sv
// Directed bench for store_rmw_controller: per-scenario tasks with hand-computed expectations.
module tb_store_rmw_controller;
    localparam int ADDR_W = 6;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    store_rmw_if #(.ADDR_W(ADDR_W)) bus ();

    store_rmw_controller #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and records strobe timing over the following cycles.
    task automatic run_store(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd_in, input logic [31:0] rdata,
                             output int rd_cyc, output int wr_cyc, output int done_cyc,
                             output int rd_cnt, output int wr_cnt,
                             output logic [31:0] wd, output logic [ADDR_W-1:0] wa,
                             output logic e, output logic m, output int stray);
        rd_cyc = -1; wr_cyc = -1; done_cyc = -1; rd_cnt = 0; wr_cnt = 0;
        wd = 32'hx; wa = 'x; e = 1'bx; m = 1'bx; stray = 0;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd_in;
        bus.mem_rdata = rdata;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.mem_rd_en === 1'b1) begin
                rd_cnt++;
                if (rd_cyc < 0) rd_cyc = c;
            end
            if (bus.mem_wr_en === 1'b1) begin
                wr_cnt++;
                wr_cyc = c;
                wd = bus.mem_wdata;
                wa = bus.mem_addr;
            end
            if (bus.done === 1'b1) begin
                done_cyc = c;
                e = bus.err;
                m = bus.misaligned;
            end else if (bus.err !== 1'b0 || bus.misaligned !== 1'b0) begin
                stray++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.funct3 = 3'h0; bus.addr = '0;
        bus.wdata = 32'h0; bus.mem_rdata = 32'h0;
        step(); step(); step();
        rst = 1'b0;
        total++;
        if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err, bus.misaligned} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 100000",
                     {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err, bus.misaligned});
        end
        total++;
        if (bus.mem_addr !== 6'h00 || bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem: got addr %h wdata %h want 00 00000000", bus.mem_addr, bus.mem_wdata);
        end
        total++;
        if (bus.fsm_state !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", bus.fsm_state);
        end
    endtask

    task automatic test_sub_word(input string name, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                                 input logic [31:0] wd_in, input logic [31:0] rdata,
                                 input logic [31:0] exp_wd, input logic [ADDR_W-1:0] exp_wa,
                                 input logic exp_m);
        int rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, stray;
        logic [31:0] wd; logic [ADDR_W-1:0] wa; logic e, m;
        run_store(f3, a, wd_in, rdata, rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, wd, wa, e, m, stray);
        total++;
        if (rd_cyc != 1 || wr_cyc != 3 || done_cyc != 4 || rd_cnt != 1 || wr_cnt != 1) begin
            bad++;
            $display("FAIL %s_timing: got rd@%0d wr@%0d done@%0d rd#%0d wr#%0d want rd@1 wr@3 done@4 rd#1 wr#1",
                     name, rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt);
        end
        total++;
        if (wd !== exp_wd || wa !== exp_wa) begin
            bad++;
            $display("FAIL %s_data: got wdata %h addr %h want %h %h", name, wd, wa, exp_wd, exp_wa);
        end
        total++;
        if (e !== 1'b0 || m !== exp_m || stray != 0) begin
            bad++;
            $display("FAIL %s_resp: got err %b mis %b stray %0d want 0 %b 0", name, e, m, stray, exp_m);
        end
    endtask

    task automatic test_sw(input string name, input logic [ADDR_W-1:0] a, input logic [31:0] wd_in,
                           input logic [ADDR_W-1:0] exp_wa, input logic exp_m);
        int rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, stray;
        logic [31:0] wd; logic [ADDR_W-1:0] wa; logic e, m;
        run_store(3'h2, a, wd_in, 32'h5555AAAA, rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, wd, wa, e, m, stray);
        total++;
        if (rd_cnt != 0 || wr_cyc != 1 || wr_cnt != 1 || done_cyc != 2) begin
            bad++;
            $display("FAIL %s_timing: got rd#%0d wr@%0d wr#%0d done@%0d want rd#0 wr@1 wr#1 done@2",
                     name, rd_cnt, wr_cyc, wr_cnt, done_cyc);
        end
        total++;
        if (wd !== wd_in || wa !== exp_wa) begin
            bad++;
            $display("FAIL %s_data: got wdata %h addr %h want %h %h", name, wd, wa, wd_in, exp_wa);
        end
        total++;
        if (e !== 1'b0 || m !== exp_m || stray != 0) begin
            bad++;
            $display("FAIL %s_resp: got err %b mis %b stray %0d want 0 %b 0", name, e, m, stray, exp_m);
        end
    endtask

    task automatic test_illegal();
        int rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, stray;
        logic [31:0] wd; logic [ADDR_W-1:0] wa; logic e, m;
        run_store(3'h4, 6'h09, 32'h12345678, 32'h0, rd_cyc, wr_cyc, done_cyc, rd_cnt, wr_cnt, wd, wa, e, m, stray);
        total++;
        if (done_cyc != 1 || rd_cnt != 0 || wr_cnt != 0) begin
            bad++;
            $display("FAIL illegal_timing: got done@%0d rd#%0d wr#%0d want done@1 rd#0 wr#0",
                     done_cyc, rd_cnt, wr_cnt);
        end
        total++;
        if (e !== 1'b1 || m !== 1'b0 || stray != 0) begin
            bad++;
            $display("FAIL illegal_resp: got err %b mis %b stray %0d want 1 0 0", e, m, stray);
        end
    endtask

    task automatic test_reset_in_wait();
        int wr_cnt;
        wr_cnt = 0;
        bus.funct3 = 3'h0; bus.addr = 6'h05; bus.wdata = 32'h000000AB;
        bus.mem_rdata = 32'h11223344; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        total++;
        if (bus.fsm_state !== 3'd2) begin
            bad++;
            $display("FAIL rst_wait_reach: got state %0d want 2", bus.fsm_state);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err, bus.misaligned} !== 6'b100000
            || bus.mem_addr !== 6'h00 || bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_wait_outputs: got flags %b addr %h wdata %h want 100000 00 00000000",
                     {bus.req_ready, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err, bus.misaligned},
                     bus.mem_addr, bus.mem_wdata);
        end
        for (int c = 0; c < 5; c++) begin
            if (bus.mem_wr_en === 1'b1) wr_cnt++;
            step();
        end
        total++;
        if (wr_cnt != 0) begin
            bad++;
            $display("FAIL rst_wait_nowrite: got %0d writes want 0", wr_cnt);
        end
    endtask

    task automatic test_reset_blocks_request();
        int strobes;
        strobes = 0;
        bus.funct3 = 3'h2; bus.addr = 6'h20; bus.wdata = 32'hFEEDF00D; bus.req_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        total++;
        if (bus.req_ready !== 1'b1 || bus.fsm_state !== 3'd0) begin
            bad++;
            $display("FAIL rst_req_ignored: got ready %b state %0d want 1 0", bus.req_ready, bus.fsm_state);
        end
        for (int c = 0; c < 4; c++) begin
            if (bus.mem_wr_en === 1'b1 || bus.mem_rd_en === 1'b1 || bus.done === 1'b1) strobes++;
            step();
        end
        total++;
        if (strobes != 0) begin
            bad++;
            $display("FAIL rst_req_strobes: got %0d want 0", strobes);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_ready [1:6];
        logic        exp_wr    [1:6];
        logic        exp_done  [1:6];
        logic [31:0] exp_wd    [1:6];
        exp_ready = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_wr    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_done  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_wd    = '{32'h0BADCAFE, 32'h0, 32'h0, 32'h600DD00D, 32'h0, 32'h0};
        bus.funct3 = 3'h2; bus.addr = 6'h14; bus.wdata = 32'h0BADCAFE; bus.req_valid = 1'b1;
        step();
        bus.wdata = 32'h600DD00D;
        for (int c = 1; c <= 6; c++) begin
            if (c == 4) bus.req_valid = 1'b0;
            total++;
            if (bus.req_ready !== exp_ready[c] || bus.mem_wr_en !== exp_wr[c] || bus.done !== exp_done[c]
                || (exp_wr[c] && bus.mem_wdata !== exp_wd[c])) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got ready %b wr %b done %b wdata %h want %b %b %b %h",
                         c, bus.req_ready, bus.mem_wr_en, bus.done, bus.mem_wdata,
                         exp_ready[c], exp_wr[c], exp_done[c], exp_wd[c]);
            end
            step();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_sub_word("sb_lane1", 3'h0, 6'h05, 32'h000000AB, 32'h11223344, 32'h1122AB44, 6'h04, 1'b0);
        test_sub_word("sb_lane3", 3'h0, 6'h23, 32'hFFFFFF5A, 32'h01020304, 32'h5A020304, 6'h20, 1'b0);
        test_sub_word("sh_hi_mis", 3'h1, 6'h0B, 32'h0000BEEF, 32'hCAFE1234, 32'hBEEF1234, 6'h08, 1'b1);
        test_sub_word("sh_lo", 3'h1, 6'h30, 32'h9999C0DE, 32'hA5A5A5A5, 32'hA5A5C0DE, 6'h30, 1'b0);
        test_sw("sw_aligned", 6'h10, 32'hDEADBEEF, 6'h10, 1'b0);
        test_sw("sw_mis", 6'h13, 32'h13579BDF, 6'h10, 1'b1);
        test_illegal();
        test_reset_in_wait();
        test_reset_blocks_request();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
